pipa_cell_request: RTL and testbench

Counter-request stage directly downstream of the four-bit module that buffers the PIPA accelerometer lines (PIPAYm_, PIPAZm_, PIPAZp_ and their siblings). It synchronizes the six active-low PIPA pulse lines, nets plus against minus per axis in a small signed backlog, and presents one counter-increment or decrement request at a time to the counter-service sequencer with a req/ack handshake. Axes are served round-robin. Pulses lost to backlog saturation are flagged.

---
 rtl/pipa_cell_request.sv | 176 +++++++++++++++++
 tb/tb_pipa_cell_request.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipa_cell_request.sv
// PIPA counter-request stage: synchronizes the six active-low pulse lines, nets them per axis
// in a saturating signed backlog, and serves one increment/decrement request at a time round-robin.

module pipa_sync_line #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLOCK,
   input  logic rst_,
   input  logic line_n,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge CLOCK or negedge rst_) begin
      if (!rst_) begin
         sync <= '1;
         prev <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], line_n};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   // One event per 1->0 transition; a line held low counts once.
   assign fall = prev & ~sync[SYNC_STAGES-1];
endmodule

module pipa_axis_backlog (
   input  logic       CLOCK,
   input  logic       rst_,
   input  logic       clr,
   input  logic       up,
   input  logic       dn,
   input  logic       ack_plus,
   input  logic       ack_minus,
   output logic [2:0] b,
   output logic       ovf
);
   logic signed [3:0] sum;
   logic [2:0]        b_next;

   // Four-bit headroom holds -5..+5 before clamping to -3..+3.
   always_comb begin
      sum    = 4'({b[2], b}) + 4'(up) - 4'(dn) - 4'(ack_plus) + 4'(ack_minus);
      ovf    = (sum > 4'sd3) || (sum < -4'sd3);
      b_next = ovf ? (sum[3] ? 3'b101 : 3'b011) : sum[2:0];
   end

   always_ff @(posedge CLOCK or negedge rst_) begin
      if (!rst_)    b <= 3'd0;
      else if (clr) b <= 3'd0;
      else          b <= b_next;
   end
endmodule

module pipa_cell_request #(
   parameter int GATE_DELAY  = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLOCK,
   input  logic       rst_,
   input  logic       PIPAXp_,
   input  logic       PIPAXm_,
   input  logic       PIPAYp_,
   input  logic       PIPAYm_,
   input  logic       PIPAZp_,
   input  logic       PIPAZm_,
   input  logic       GOJAM,
   input  logic       CTR_ACK,
   output logic       CTR_REQ,
   output logic [1:0] CTR_AXIS,
   output logic       CTR_DIR,
   output logic       PIPDRP
);
   if (SYNC_STAGES < 2 || GATE_DELAY < 0) begin : g_param_check
      $error("pipa_cell_request: SYNC_STAGES must be >= 2 and GATE_DELAY >= 0");
   end

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t          state;
   logic [1:0]      rr;
   logic [5:0]      line_n;
   logic [5:0]      fall;
   logic [2:0][2:0] b;
   logic [2:0]      ovf;
   logic            ack_take;

   // Line order: even index = plus, odd index = minus, two lines per axis.
   assign line_n   = {PIPAZm_, PIPAZp_, PIPAYm_, PIPAYp_, PIPAXm_, PIPAXp_};
   assign ack_take = (state == PRESENT) & CTR_ACK;

   for (genvar i = 0; i < 6; i++) begin : g_sync
      pipa_sync_line #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .CLOCK (CLOCK),
         .rst_  (rst_),
         .line_n(line_n[i]),
         .fall  (fall[i])
      );
   end

   for (genvar a = 0; a < 3; a++) begin : g_axis
      pipa_axis_backlog u_blog (
         .CLOCK    (CLOCK),
         .rst_     (rst_),
         .clr      (GOJAM),
         .up       (fall[2*a]),
         .dn       (fall[2*a+1]),
         .ack_plus (ack_take & (CTR_AXIS == 2'(a)) & ~CTR_DIR),
         .ack_minus(ack_take & (CTR_AXIS == 2'(a)) &  CTR_DIR),
         .b        (b[a]),
         .ovf      (ovf[a])
      );
   end

   logic [2:0] idx;
   logic [2:0] cur_b;
   logic       pick_vld;
   logic [1:0] pick_axis;

   // Scan from rr downward in priority so the first nonzero axis after rr wins.
   always_comb begin
      pick_vld  = 1'b0;
      pick_axis = 2'd0;
      idx       = 3'd0;
      for (int i = 2; i >= 0; i--) begin
         idx = {1'b0, rr} + 3'(i);
         if (idx >= 3'd3) idx = idx - 3'd3;
         if (b[idx[1:0]] != 3'd0) begin
            pick_vld  = 1'b1;
            pick_axis = idx[1:0];
         end
      end
      cur_b = b[CTR_AXIS];
   end

   always_ff @(posedge CLOCK or negedge rst_) begin
      if (!rst_) begin
         state    <= IDLE;
         rr       <= 2'd0;
         CTR_REQ  <= 1'b0;
         CTR_AXIS <= 2'd0;
         CTR_DIR  <= 1'b0;
      end else if (GOJAM) begin
         state   <= IDLE;
         rr      <= 2'd0;
         CTR_REQ <= 1'b0;
      end else begin
         case (state)
            IDLE: if (pick_vld) begin
               state    <= PRESENT;
               CTR_REQ  <= 1'b1;
               CTR_AXIS <= pick_axis;
               CTR_DIR  <= b[pick_axis][2];
            end
            PRESENT: if (CTR_ACK) begin
               state   <= IDLE;
               CTR_REQ <= 1'b0;
               rr      <= (CTR_AXIS == 2'd2) ? 2'd0 : CTR_AXIS + 2'd1;
            end else if (cur_b == 3'd0 || cur_b[2] != CTR_DIR) begin
               // Opposing pulses drained or flipped the backlog: withdraw, rr unchanged.
               state   <= IDLE;
               CTR_REQ <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK or negedge rst_) begin
      if (!rst_)       PIPDRP <= 1'b0;
      else if (GOJAM)  PIPDRP <= 1'b0;
      else if (|ovf)   PIPDRP <= 1'b1;
   end
endmodule

// File: tb/tb_pipa_cell_request.sv
// Directed bench for pipa_cell_request: stimulus pushes expected {axis,dir} of each request
// into a queue, a negedge monitor pops and compares on every new rising CTR_REQ.

module tb_pipa_cell_request;
   logic       CLOCK = 1'b0;
   logic       rst_ = 1'b0;
   logic       GOJAM = 1'b0;
   logic       CTR_ACK = 1'b0;
   logic [5:0] lines_n = 6'h3F;   // 0:Xp 1:Xm 2:Yp 3:Ym 4:Zp 5:Zm
   logic       CTR_REQ, CTR_DIR, PIPDRP;
   logic [1:0] CTR_AXIS;

   int         checks = 0;
   int         fails = 0;
   logic [2:0] exp_q[$];          // {axis, dir}
   logic       prev_req = 1'b0;
   logic [2:0] e;

   always #5 CLOCK = ~CLOCK;

   pipa_cell_request #(.GATE_DELAY(20), .SYNC_STAGES(2)) dut (
      .CLOCK   (CLOCK),
      .rst_    (rst_),
      .PIPAXp_ (lines_n[0]),
      .PIPAXm_ (lines_n[1]),
      .PIPAYp_ (lines_n[2]),
      .PIPAYm_ (lines_n[3]),
      .PIPAZp_ (lines_n[4]),
      .PIPAZm_ (lines_n[5]),
      .GOJAM   (GOJAM),
      .CTR_ACK (CTR_ACK),
      .CTR_REQ (CTR_REQ),
      .CTR_AXIS(CTR_AXIS),
      .CTR_DIR (CTR_DIR),
      .PIPDRP  (PIPDRP)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!CTR_REQ && n < 20) begin
         cyc(1);
         n++;
      end
      chk(name, int'(CTR_REQ), 1);
   endtask

   // Scoreboard monitor
   always @(negedge CLOCK) begin
      if (CTR_REQ && !prev_req) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected request: axis %0d dir %0d, none expected", CTR_AXIS, CTR_DIR);
         end else begin
            e = exp_q.pop_front();
            chk("sb axis", int'(CTR_AXIS), int'(e[2:1]));
            chk("sb dir", int'(CTR_DIR), int'(e[0]));
         end
      end
      prev_req = CTR_REQ;
   end

   initial begin
      // Reset state
      cyc(2);
      chk("rst req", int'(CTR_REQ), 0);
      chk("rst axis", int'(CTR_AXIS), 0);
      chk("rst dir", int'(CTR_DIR), 0);
      chk("rst drp", int'(PIPDRP), 0);
      rst_ = 1'b1;
      cyc(2);

      // Single minus pulse on Y, held 3 cycles
      exp_q.push_back(3'b011);
      lines_n[3] = 1'b0;
      cyc(3);
      chk("t1 req at k+2", int'(CTR_REQ), 0);
      lines_n[3] = 1'b1;
      cyc(1);
      chk("t1 req at k+3", int'(CTR_REQ), 1);
      chk("t1 axis", int'(CTR_AXIS), 1);
      chk("t1 dir", int'(CTR_DIR), 1);
      CTR_ACK = 1'b1;
      cyc(1);
      CTR_ACK = 1'b0;
      chk("t1 req after ack", int'(CTR_REQ), 0);
      cyc(6);
      chk("t1 stays idle", int'(CTR_REQ), 0);

      // Round-robin from reset: X, Y, Z plus in the same cycle
      rst_ = 1'b0;
      cyc(2);
      rst_ = 1'b1;
      cyc(1);
      exp_q.push_back(3'b000);
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b100);
      lines_n[0] = 1'b0; lines_n[2] = 1'b0; lines_n[4] = 1'b0;
      cyc(1);
      lines_n = 6'h3F;
      wait_req("t2 first req");
      for (int i = 0; i < 3; i++) begin
         CTR_ACK = 1'b1;
         cyc(1);
         CTR_ACK = 1'b0;
         chk("t2 gap after ack", int'(CTR_REQ), 0);
         cyc(1);
         chk("t2 alternate req", int'(CTR_REQ), (i < 2) ? 1 : 0);
      end
      cyc(4);
      chk("t2 idle", int'(CTR_REQ), 0);

      // Cancellation on Z, no ack
      exp_q.push_back(3'b100);
      lines_n[4] = 1'b0;
      cyc(1); lines_n[4] = 1'b1;
      cyc(1); lines_n[5] = 1'b0;
      cyc(1); lines_n[5] = 1'b1;
      cyc(1);
      chk("t3 req up", int'(CTR_REQ), 1);
      chk("t3 axis", int'(CTR_AXIS), 2);
      chk("t3 dir", int'(CTR_DIR), 0);
      cyc(1);
      chk("t3 req before withdraw", int'(CTR_REQ), 1);
      cyc(1);
      chk("t3 withdrawn", int'(CTR_REQ), 0);
      chk("t3 no drop", int'(PIPDRP), 0);
      cyc(5);
      chk("t3 idle", int'(CTR_REQ), 0);

      // Saturation: five X plus pulses, then three services
      repeat (3) exp_q.push_back(3'b000);
      for (int p = 0; p < 5; p++) begin
         lines_n[0] = 1'b0;
         cyc(1);
         lines_n[0] = 1'b1;
         cyc(3);
      end
      cyc(2);
      chk("t4 drop set", int'(PIPDRP), 1);
      chk("t4 presented", int'(CTR_REQ), 1);
      for (int i = 0; i < 3; i++) begin
         wait_req("t4 service req");
         CTR_ACK = 1'b1;
         cyc(1);
         CTR_ACK = 1'b0;
         chk("t4 gap after ack", int'(CTR_REQ), 0);
      end
      cyc(6);
      chk("t4 drained", int'(CTR_REQ), 0);
      chk("t4 drop sticky", int'(PIPDRP), 1);

      // Ack and opposing pulse on the same edge
      exp_q.push_back(3'b000);
      lines_n[0] = 1'b0;
      cyc(1); lines_n[0] = 1'b1;
      cyc(3);
      chk("t5 req up", int'(CTR_REQ), 1);
      lines_n[1] = 1'b0;
      cyc(1); lines_n[1] = 1'b1;
      cyc(1);
      chk("t5 still presented", int'(CTR_REQ), 1);
      exp_q.push_back(3'b001);
      CTR_ACK = 1'b1;
      cyc(1);
      CTR_ACK = 1'b0;
      chk("t5 gap", int'(CTR_REQ), 0);
      cyc(1);
      chk("t5 minus req", int'(CTR_REQ), 1);
      chk("t5 axis", int'(CTR_AXIS), 0);
      chk("t5 dir", int'(CTR_DIR), 1);
      CTR_ACK = 1'b1;
      cyc(1);
      CTR_ACK = 1'b0;
      cyc(5);
      chk("t5 idle", int'(CTR_REQ), 0);

      // GOJAM with backlog on Y and Z
      exp_q.push_back(3'b010);
      lines_n[2] = 1'b0; lines_n[5] = 1'b0;
      cyc(1);
      lines_n = 6'h3F;
      wait_req("t6 req");
      chk("t6 axis", int'(CTR_AXIS), 1);
      GOJAM = 1'b1;
      cyc(1);
      GOJAM = 1'b0;
      chk("t6 req cleared", int'(CTR_REQ), 0);
      chk("t6 drop cleared", int'(PIPDRP), 0);
      cyc(8);
      chk("t6 no requests", int'(CTR_REQ), 0);

      // Asynchronous reset mid-PRESENT on a Z minus request
      exp_q.push_back(3'b101);
      lines_n[5] = 1'b0;
      cyc(1);
      lines_n[5] = 1'b1;
      wait_req("t7 req");
      chk("t7 axis", int'(CTR_AXIS), 2);
      #2 rst_ = 1'b0;
      #1;
      chk("t7 req async", int'(CTR_REQ), 0);
      chk("t7 axis async", int'(CTR_AXIS), 0);
      chk("t7 dir async", int'(CTR_DIR), 0);
      chk("t7 drp async", int'(PIPDRP), 0);
      cyc(1);
      rst_ = 1'b1;
      CTR_ACK = 1'b1;
      cyc(1);
      CTR_ACK = 1'b0;
      cyc(6);
      chk("t7 ack ignored", int'(CTR_REQ), 0);

      chk("scoreboard empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
